// File: rtl/sram_pkg.sv
// Shared types, default widths and the parity helper for the burst SRAM controller.
// SRAM_PARITY_EN selects the parity-protected memory build.
package sram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_BURST_W    = 3;
    localparam int PARITY_MAX_W       = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    // Even parity; callers zero-extend, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [PARITY_MAX_W-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/sram_shift_in.sv
// Serial-to-parallel deserialiser, MSB first, with a one-cycle word_full pulse.
// clear_i restarts word alignment and suppresses a pending pulse.
module sram_shift_in #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  serial_in_i,
    input  logic                  shift_i,
    input  logic                  clear_i,
    output logic [DATA_WIDTH-1:0] sr_o,
    output logic                  word_full_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  word_full_q, word_full_d;

    always_comb begin
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        word_full_d = 1'b0;
        if (shift_i) begin
            sr_d = {sr_q[DATA_WIDTH-2:0], serial_in_i};
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d   = '0;
                word_full_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
        // Bits gathered before a command are never counted toward its words.
        if (clear_i) begin
            bit_cnt_d   = '0;
            word_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            word_full_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            word_full_q <= word_full_d;
        end
    end

    assign sr_o        = sr_q;
    assign word_full_o = word_full_q;

endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst SRAM controller: serial word loading, register-file array, wrapping burst FSM.
// Define SRAM_PARITY_EN to store an even-parity bit per word and flag read mismatches.
module sram_burst_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int BURST_W    = DEFAULT_BURST_W
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  serial_in,
    input  logic                  shift,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BURST_W-1:0]    burst_len,
    output logic                  busy,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  parity_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef SRAM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [BURST_W-1:0]    remaining_q;
    logic                  busy_q, data_valid_q, done_q;
    logic [DATA_WIDTH-1:0] data_out_q;

    logic [MEM_W-1:0]      mem_q [DEPTH];
    logic [MEM_W-1:0]      wr_word, rd_word;
    logic [DATA_WIDTH-1:0] sr;
    logic                  word_full, accept, mem_we;

    assign accept = (state_q == IDLE) && (w_en || r_en);
    assign mem_we = (state_q == WRITE) && word_full;

    sram_shift_in #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift_in (
        .clk         (clk),
        .arst_n      (arst_n),
        .serial_in_i (serial_in),
        .shift_i     (shift),
        .clear_i     (accept),
        .sr_o        (sr),
        .word_full_o (word_full)
    );

`ifdef SRAM_PARITY_EN
    logic parity_err_q;
    assign wr_word    = {parity_bit(PARITY_MAX_W'(sr)), sr};
    assign parity_err = parity_err_q;
`else
    assign wr_word    = sr;
    assign parity_err = 1'b0;
`endif

    // Array deliberately has no reset so it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= wr_word;
        end
    end

    assign rd_word = mem_q[ptr_q];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            remaining_q  <= '0;
            busy_q       <= 1'b0;
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
            data_out_q   <= '0;
`ifdef SRAM_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_en || r_en) begin
                        state_q     <= w_en ? WRITE : READ;
                        busy_q      <= 1'b1;
                        ptr_q       <= addr;
                        remaining_q <= burst_len;
                    end
                end
                WRITE: begin
                    if (word_full) begin
                        ptr_q <= ptr_q + ADDR_WIDTH'(1);
                        if (remaining_q == '0) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            remaining_q <= remaining_q - BURST_W'(1);
                        end
                    end
                end
                READ: begin
                    data_out_q   <= rd_word[DATA_WIDTH-1:0];
                    data_valid_q <= 1'b1;
`ifdef SRAM_PARITY_EN
                    parity_err_q <= parity_bit(PARITY_MAX_W'(rd_word[DATA_WIDTH-1:0]))
                                    != rd_word[DATA_WIDTH];
`endif
                    ptr_q <= ptr_q + ADDR_WIDTH'(1);
                    if (remaining_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        remaining_q <= remaining_q - BURST_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign data_valid = data_valid_q;
    assign data_out   = data_out_q;
    assign done       = done_q;

endmodule
